// File: rtl/fold_rr_arbiter.sv
// Round-robin arbiter sharing one XOR-fold unit between NREQ word producers.
// Each accepted DW-bit word is folded to DW/2 bits (low half XOR high half) and held
// in a single registered output stage tagged with the winning requester index.
module fold_rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 16,
    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 out_valid,
    output logic [DW/2-1:0]      out_data,
    output logic [IDW-1:0]       out_id,
    input  logic                 out_ready,
    output logic [15:0]          xfer_cnt
);

    logic                 out_valid_q, out_valid_d;
    logic [DW/2-1:0]      out_data_q, out_data_d;
    logic [IDW-1:0]       out_id_q, out_id_d;
    logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [15:0]          xfer_cnt_q, xfer_cnt_d;

    logic                 grant_valid;
    logic [IDW-1:0]       grant_idx;
    logic [DW-1:0]        sel_word;
    logic                 can_accept;
    logic                 accept;
    logic                 drain;

    // Find the first valid requester at or after the round-robin pointer.
    always_comb begin
        int idx;
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = 0; k < int'(NREQ); k++) begin
            idx = (int'(rr_ptr_q) + k) % int'(NREQ);
            if (!grant_valid && req_valid[IDW'(idx)]) begin
                grant_valid = 1'b1;
                grant_idx   = IDW'(idx);
            end
        end
    end

    // Handshake decode; out_ready feeds req_ready combinationally so a full stage
    // can drain and refill in the same cycle.
    always_comb begin
        drain      = out_valid_q && out_ready;
        can_accept = !out_valid_q || out_ready;
        accept     = rst_n && grant_valid && can_accept;
        req_ready  = '0;
        sel_word   = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (grant_idx == IDW'(i)) begin
                sel_word     = req_data[i*DW +: DW];
                req_ready[i] = accept;
            end
        end
    end

    // Next-state for the output stage, pointer and delivery counter.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        rr_ptr_d    = rr_ptr_q;
        xfer_cnt_d  = xfer_cnt_q + 16'(drain);
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_word[DW/2-1:0] ^ sel_word[DW-1:DW/2];
            out_id_d    = grant_idx;
            rr_ptr_d    = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        end else if (drain) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            rr_ptr_q    <= '0;
            xfer_cnt_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            rr_ptr_q    <= rr_ptr_d;
            xfer_cnt_q  <= xfer_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;
    assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_fold_rr_arbiter.sv
// Self-checking bench for fold_rr_arbiter: directed steps followed by random traffic,
// all compared against a behavioural model of the arbitration and output stage.
module tb_fold_rr_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 16;
    localparam int IDW  = 2;

    logic                 clk;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 out_valid;
    logic [DW/2-1:0]      out_data;
    logic [IDW-1:0]       out_id;
    logic                 out_ready;
    logic [15:0]          xfer_cnt;

    int checks = 0;
    int fails  = 0;

    // Model state
    bit             m_valid;
    logic [7:0]     m_data;
    int             m_id;
    int             m_ptr;
    int             m_cnt;
    int             last_grant;

    fold_rr_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ready (out_ready),
        .xfer_cnt  (xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] fold_word(input logic [15:0] w);
        logic [7:0] r;
        for (int b = 0; b < 8; b++) r[b] = w[b] ^ w[b + 8];
        return r;
    endfunction

    // One clock: check req_ready before the edge, advance model, check outputs after.
    task automatic cycle();
        int g;
        bit can;
        logic [NREQ-1:0] exp_ready;
        #1;
        g = -1;
        if (rst_n === 1'b1) begin
            for (int k = 0; k < NREQ; k++) begin
                if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
            end
        end
        can = !m_valid || out_ready;
        exp_ready = '0;
        if (g >= 0 && can) exp_ready[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        @(posedge clk);
        last_grant = -1;
        if (rst_n !== 1'b1) begin
            m_valid = 0; m_data = 8'h00; m_id = 0; m_ptr = 0; m_cnt = 0;
        end else begin
            if (m_valid && out_ready) m_cnt = (m_cnt + 1) % 65536;
            if (g >= 0 && can) begin
                m_data  = fold_word(req_data[g*DW +: DW]);
                m_id    = g;
                m_valid = 1;
                m_ptr   = (g + 1) % NREQ;
                last_grant = g;
            end else if (m_valid && out_ready) begin
                m_valid = 0;
            end
        end
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_data", 32'(out_data), 32'(m_data));
        chk("out_id", 32'(out_id), 32'(m_id));
        chk("xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
    endtask

    task automatic drive(input logic [NREQ-1:0] v, input logic ordy);
        req_valid = v;
        out_ready = ordy;
    endtask

    initial begin
        m_valid = 0; m_data = 0; m_id = 0; m_ptr = 0; m_cnt = 0; last_grant = -1;
        rst_n = 1'b0;
        out_ready = 1'b1;
        req_valid = '1;
        for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = 16'(32'h1111 * (i + 1));

        // Reset with every requester valid
        cycle();
        cycle();
        chk("reset_out_valid", 32'(out_valid), 32'h0);
        chk("reset_xfer_cnt", 32'(xfer_cnt), 32'h0);
        rst_n = 1'b1;

        // Single word from requester 0
        req_data[15:0] = 16'h1234;
        drive(4'b0001, 1'b1);
        cycle();
        chk("single_fold", 32'(out_data), 32'h26);
        chk("single_id", 32'(out_id), 32'h0);
        drive(4'b0000, 1'b1);
        cycle();
        chk("single_cnt", 32'(xfer_cnt), 32'h1);

        // Round robin with all valid; pointer is 1 here, so start at 1
        drive(4'b1111, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("rr_grant", 32'(out_id), 32'((1 + i) % NREQ));
            chk("rr_valid", 32'(out_valid), 32'h1);
        end
        drive(4'b0000, 1'b1);
        cycle();

        // Backpressure: fill with ABCD from requester 2 (pointer is 2), then stall
        req_data[2*DW +: DW] = 16'hABCD;
        drive(4'b0100, 1'b1);
        cycle();
        chk("bp_fill", 32'(out_data), 32'h66);
        req_data[2*DW +: DW] = 16'h0F0F;
        drive(4'b0100, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_stable", 32'(out_data), 32'h66);
        end
        drive(4'b0100, 1'b1);
        cycle();
        chk("bp_no_bubble", 32'(out_valid), 32'h1);
        chk("bp_new_data", 32'(out_data), 32'h00);

        // Pointer after grant to 2: 1010 -> 3 then 1
        drive(4'b1010, 1'b1);
        cycle();
        chk("ptr_first", 32'(out_id), 32'h3);
        cycle();
        chk("ptr_second", 32'(out_id), 32'h1);
        drive(4'b0000, 1'b1);
        for (int i = 0; i < 5; i++) cycle();
        drive(4'b1111, 1'b1);
        cycle();
        chk("ptr_held", 32'(out_id), 32'h2);

        // Counter wrap: preload near the top, then deliver two results
        force dut.xfer_cnt_q = 16'hFFFE;
        #1;
        release dut.xfer_cnt_q;
        m_cnt = 65534;
        cycle();
        cycle();
        chk("cnt_wrap", 32'(xfer_cnt), 32'h0);

        // Random traffic, including occasional mid-operation reset
        for (int n = 0; n < 400; n++) begin
            rst_n     = ($urandom_range(0, 49) != 0);
            req_valid = NREQ'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = 16'($urandom);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule
